// File: rtl/cluster_demux_pkg.sv
// Shared types and helpers for the cluster core data-bus demultiplexer.
//   rule_t      : one address-map entry, {base, mask}; an address hits the
//                 entry when (addr & mask) == base.
//   ERR_RDATA   : read data returned for accesses that hit no entry.
//   rule_hit()  : single-entry match used by the decoder.
// Rule fields are 32 bits wide; narrower bus addresses are zero-extended
// before the compare and wider ones are truncated to 32 bits.
package cluster_demux_pkg;

  localparam int RULE_AW = 32;

  typedef struct packed {
    logic [RULE_AW-1:0] base;
    logic [RULE_AW-1:0] mask;
  } rule_t;

  localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

  function automatic logic rule_hit(input logic [RULE_AW-1:0] addr,
                                    input rule_t              rule);
    return (addr & rule.mask) == rule.base;
  endfunction

endpackage

// File: rtl/cluster_demux_decode.sv
// Address decoder for the core demux.
// Ports:
//   addr : core address
//   sel  : index of the lowest-numbered matching rule, or N_TARGETS on a miss
//   miss : 1 when no rule matches (sel then names the error pseudo-target)
module cluster_demux_decode
  import cluster_demux_pkg::*;
#(
  parameter int    ADDR_WIDTH          = 32,
  parameter int    N_TARGETS           = 3,
  parameter rule_t RULES [N_TARGETS]   = '{default: '0}
) (
  input  logic [ADDR_WIDTH-1:0]              addr,
  output logic [$clog2(N_TARGETS+1)-1:0]     sel,
  output logic                               miss
);

  localparam int SEL_W = $clog2(N_TARGETS + 1);

  logic [RULE_AW-1:0] addr_ext;

  assign addr_ext = RULE_AW'(addr);

  // Walk from the highest index down so the lowest matching index is the
  // last assignment and therefore wins.
  always_comb begin
    sel  = SEL_W'(N_TARGETS);
    miss = 1'b1;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (rule_hit(addr_ext, RULES[i])) begin
        sel  = SEL_W'(i);
        miss = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cluster_core_demux_n.sv
// Core data-bus demultiplexer: routes one core load/store port to
// N_TARGETS address-mapped targets, answers unmapped accesses with an error
// response, keeps responses in order and counts per-target stall cycles.
//
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   core_req_i .. core_be_i : core request (wen = 1 means read)
//   core_gnt_o              : grant back to the core
//   core_r_valid/data/opc_o : response to the core (opc = error flag)
//   tgt_req_o               : one-hot request to the selected target
//   tgt_add/wen/data/be_o   : request fields broadcast to every target
//   tgt_gnt_i               : per-target grant
//   tgt_r_valid/data/opc_i  : per-target response
//   perf_clr_i              : synchronous clear of the stall counters
//   perf_stall_o            : per-target stall event this cycle
//   perf_cnt_o              : per-target saturating stall-cycle counters
//
// Handshake: a request transfers in the cycle where req and gnt are both 1;
// req may be held across cycles without a grant and the fields must stay
// stable while it is. Responses carry no back-pressure: a response is
// consumed in the cycle its r_valid is 1.
//
// Ordering: every in-flight transaction targets cur_tgt. A request to a
// different target waits until the registered outstanding count is zero,
// so responses can only ever come back from one target at a time.
module cluster_core_demux_n
  import cluster_demux_pkg::*;
#(
  parameter int    ADDR_WIDTH          = 32,
  parameter int    DATA_WIDTH          = 32,
  parameter int    BE_WIDTH            = DATA_WIDTH / 8,
  parameter int    N_TARGETS           = 3,
  parameter int    MAX_OUTSTANDING     = 4,
  parameter int    PERF_CNT_WIDTH      = 16,
  parameter rule_t RULES [N_TARGETS]   = '{default: '0}
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      core_req_i,
  input  logic [ADDR_WIDTH-1:0]                     core_add_i,
  input  logic                                      core_wen_i,
  input  logic [DATA_WIDTH-1:0]                     core_data_i,
  input  logic [BE_WIDTH-1:0]                       core_be_i,
  output logic                                      core_gnt_o,
  output logic                                      core_r_valid_o,
  output logic [DATA_WIDTH-1:0]                     core_r_data_o,
  output logic                                      core_r_opc_o,
  output logic [N_TARGETS-1:0]                      tgt_req_o,
  output logic [ADDR_WIDTH-1:0]                     tgt_add_o,
  output logic                                      tgt_wen_o,
  output logic [DATA_WIDTH-1:0]                     tgt_data_o,
  output logic [BE_WIDTH-1:0]                       tgt_be_o,
  input  logic [N_TARGETS-1:0]                      tgt_gnt_i,
  input  logic [N_TARGETS-1:0]                      tgt_r_valid_i,
  input  logic [N_TARGETS-1:0][DATA_WIDTH-1:0]      tgt_r_data_i,
  input  logic [N_TARGETS-1:0]                      tgt_r_opc_i,
  input  logic                                      perf_clr_i,
  output logic [N_TARGETS-1:0]                      perf_stall_o,
  output logic [N_TARGETS-1:0][PERF_CNT_WIDTH-1:0]  perf_cnt_o
);

  localparam int SEL_W = $clog2(N_TARGETS + 1);
  localparam int TGT_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_RDATA);

  logic [SEL_W-1:0] sel;
  logic [TGT_W-1:0] sel_idx;
  logic             miss;

  logic [CNT_W-1:0] cnt;
  logic [TGT_W-1:0] cur_tgt;
  logic             err_pend;

  logic             ok;
  logic             err_gnt;
  logic             tgt_gnt_hit;
  logic             resp_acc;

  cluster_demux_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_TARGETS  (N_TARGETS),
    .RULES      (RULES)
  ) u_decode (
    .addr (core_add_i),
    .sel  (sel),
    .miss (miss)
  );

  // Only meaningful when miss == 0, i.e. sel < N_TARGETS.
  assign sel_idx = TGT_W'(sel);

  assign tgt_add_o  = core_add_i;
  assign tgt_wen_o  = core_wen_i;
  assign tgt_data_o = core_data_i;
  assign tgt_be_o   = core_be_i;

  // Issue logic works on the registered count only: a response arriving in
  // the same cycle frees a slot for the next cycle, not this one.
  always_comb begin
    ok = (cnt == '0) ||
         (!miss && (sel == SEL_W'(cur_tgt)) && (cnt < CNT_W'(MAX_OUTSTANDING)));
    tgt_req_o = '0;
    if (core_req_i && ok && !miss) begin
      tgt_req_o[sel_idx] = 1'b1;
    end
    tgt_gnt_hit = |(tgt_req_o & tgt_gnt_i);
    // Unmapped accesses are answered locally, but only from an empty
    // pipeline so the error response cannot overtake target responses.
    err_gnt    = core_req_i && miss && (cnt == '0);
    core_gnt_o = tgt_gnt_hit || err_gnt;
  end

  // Responses from anything but cur_tgt, or with nothing in flight, are
  // dropped here and never reach the core or the counter.
  assign resp_acc = (cnt != '0) && tgt_r_valid_i[cur_tgt];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      cur_tgt  <= '0;
      err_pend <= 1'b0;
    end else begin
      if (tgt_gnt_hit && !resp_acc) begin
        cnt <= cnt + CNT_W'(1);
      end else if (!tgt_gnt_hit && resp_acc) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (tgt_gnt_hit) begin
        cur_tgt <= sel_idx;
      end
      err_pend <= err_gnt;
    end
  end

  // err_pend and resp_acc cannot coincide: an error grant needs cnt == 0
  // and leaves cnt untouched, so nothing is in flight on the next cycle.
  always_comb begin
    core_r_valid_o = 1'b0;
    core_r_opc_o   = 1'b0;
    core_r_data_o  = '0;
    if (err_pend) begin
      core_r_valid_o = 1'b1;
      core_r_opc_o   = 1'b1;
      core_r_data_o  = ERR_DATA;
    end else if (resp_acc) begin
      core_r_valid_o = 1'b1;
      core_r_opc_o   = tgt_r_opc_i[cur_tgt];
      core_r_data_o  = tgt_r_data_i[cur_tgt];
    end
  end

  // A stall is a request that decodes to a real target but is not granted,
  // whether blocked by ordering/occupancy or by the target itself.
  always_comb begin
    perf_stall_o = '0;
    if (core_req_i && !miss && !core_gnt_o) begin
      perf_stall_o[sel_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cnt_o <= '0;
    end else begin
      for (int i = 0; i < N_TARGETS; i++) begin
        if (perf_clr_i) begin
          perf_cnt_o[i] <= '0;
        end else if (perf_stall_o[i] && (perf_cnt_o[i] != '1)) begin
          perf_cnt_o[i] <= perf_cnt_o[i] + PERF_CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cluster_core_demux_n.sv
// Bench for cluster_core_demux_n. Two instances share all inputs:
// dut_a uses the default depth (MAX_OUTSTANDING=4, 16-bit counters) and
// dut_b a shallow one (MAX_OUTSTANDING=2, 4-bit counters).
module tb_cluster_core_demux_n;
  import cluster_demux_pkg::*;

  localparam rule_t TB_RULES [3] = '{
    '{base: 32'h1000_0000, mask: 32'hFFF0_0000},
    '{base: 32'h2000_0000, mask: 32'hFFF0_0000},
    '{base: 32'h1000_0000, mask: 32'hF000_0000}
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic             req;
  logic [31:0]      add;
  logic             wen;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic [2:0]       tgt_gnt;
  logic [2:0]       tgt_rv;
  logic [2:0][31:0] tgt_rd;
  logic [2:0]       tgt_ro;
  logic             clr;

  // ---------------- outputs ----------------
  logic gnt_a, rv_a, ro_a, twen_a;
  logic [31:0] rd_a, tadd_a, tdata_a;
  logic [3:0]  tbe_a;
  logic [2:0]  treq_a, stall_a;
  logic [2:0][15:0] pc_a;

  logic gnt_b, rv_b, ro_b, twen_b;
  logic [31:0] rd_b, tadd_b, tdata_b;
  logic [3:0]  tbe_b;
  logic [2:0]  treq_b, stall_b;
  logic [2:0][3:0] pc_b;

  cluster_core_demux_n #(
    .N_TARGETS(3), .MAX_OUTSTANDING(4), .PERF_CNT_WIDTH(16), .RULES(TB_RULES)
  ) dut_a (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(req), .core_add_i(add), .core_wen_i(wen),
    .core_data_i(wdata), .core_be_i(be),
    .core_gnt_o(gnt_a), .core_r_valid_o(rv_a), .core_r_data_o(rd_a),
    .core_r_opc_o(ro_a),
    .tgt_req_o(treq_a), .tgt_add_o(tadd_a), .tgt_wen_o(twen_a),
    .tgt_data_o(tdata_a), .tgt_be_o(tbe_a),
    .tgt_gnt_i(tgt_gnt), .tgt_r_valid_i(tgt_rv), .tgt_r_data_i(tgt_rd),
    .tgt_r_opc_i(tgt_ro),
    .perf_clr_i(clr), .perf_stall_o(stall_a), .perf_cnt_o(pc_a)
  );

  cluster_core_demux_n #(
    .N_TARGETS(3), .MAX_OUTSTANDING(2), .PERF_CNT_WIDTH(4), .RULES(TB_RULES)
  ) dut_b (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(req), .core_add_i(add), .core_wen_i(wen),
    .core_data_i(wdata), .core_be_i(be),
    .core_gnt_o(gnt_b), .core_r_valid_o(rv_b), .core_r_data_o(rd_b),
    .core_r_opc_o(ro_b),
    .tgt_req_o(treq_b), .tgt_add_o(tadd_b), .tgt_wen_o(twen_b),
    .tgt_data_o(tdata_b), .tgt_be_o(tbe_b),
    .tgt_gnt_i(tgt_gnt), .tgt_r_valid_i(tgt_rv), .tgt_r_data_i(tgt_rd),
    .tgt_r_opc_i(tgt_ro),
    .perf_clr_i(clr), .perf_stall_o(stall_b), .perf_cnt_o(pc_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input int d, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s @%0t: got %0h want %0h", d, name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: number of transactions in flight, the target they all
  // belong to, whether an error answer is owed next cycle, stall tallies.
  logic [31:0] m_base [3] = '{32'h1000_0000, 32'h2000_0000, 32'h1000_0000};
  logic [31:0] m_mask [3] = '{32'hFFF0_0000, 32'hFFF0_0000, 32'hF000_0000};
  int max_out [2] = '{4, 2};
  int sat     [2] = '{65535, 15};
  int m_cnt [2] = '{0, 0};
  int m_cur [2] = '{0, 0};
  bit m_err [2] = '{0, 0};
  int m_pc  [2][3];

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++) begin
      if ((a & m_mask[i]) == m_base[i]) return i;
    end
    return 3;
  endfunction

  task automatic check_dut(input int d, input logic a_gnt, input logic a_rv,
                           input logic a_ro, input logic [31:0] a_rd,
                           input logic [2:0] a_treq, input logic [2:0] a_stall,
                           input logic [31:0] a_tadd, input logic a_twen,
                           input logic [31:0] a_tdata, input logic [3:0] a_tbe,
                           input int a_pc0, input int a_pc1, input int a_pc2);
    int s;
    bit may_issue;
    bit take;
    logic [2:0] e_treq, e_stall;
    logic e_gnt, e_rv, e_ro;
    logic [31:0] e_rd;
    if (rst) begin
      m_cnt[d] = 0;
      m_cur[d] = 0;
      m_err[d] = 0;
      for (int i = 0; i < 3; i++) m_pc[d][i] = 0;
    end
    s = decode(add);
    may_issue = (m_cnt[d] == 0) || (s < 3 && s == m_cur[d] && m_cnt[d] < max_out[d]);
    e_treq = '0;
    if (req && may_issue && s < 3) e_treq[s] = 1'b1;
    if (s < 3) e_gnt = e_treq[s] & tgt_gnt[s];
    else       e_gnt = req && (m_cnt[d] == 0);
    take = (m_cnt[d] > 0) && tgt_rv[m_cur[d]];
    e_rv = 1'b0; e_ro = 1'b0; e_rd = '0;
    if (m_err[d]) begin
      e_rv = 1'b1; e_ro = 1'b1; e_rd = 32'hBADA_CCE5;
    end else if (take) begin
      e_rv = 1'b1; e_ro = tgt_ro[m_cur[d]]; e_rd = tgt_rd[m_cur[d]];
    end
    e_stall = '0;
    if (req && s < 3 && !e_gnt) e_stall[s] = 1'b1;

    cmp(d, "gnt", 64'(a_gnt), 64'(e_gnt));
    cmp(d, "tgt_req", 64'(a_treq), 64'(e_treq));
    cmp(d, "r_valid", 64'(a_rv), 64'(e_rv));
    cmp(d, "r_opc", 64'(a_ro), 64'(e_ro));
    cmp(d, "r_data", 64'(a_rd), 64'(e_rd));
    cmp(d, "stall", 64'(a_stall), 64'(e_stall));
    cmp(d, "bcast", {a_tadd, a_tdata}, {add, wdata});
    cmp(d, "bcast_wen_be", 64'({a_twen, a_tbe}), 64'({wen, be}));
    cmp(d, "pc0", 64'(a_pc0), 64'(m_pc[d][0]));
    cmp(d, "pc1", 64'(a_pc1), 64'(m_pc[d][1]));
    cmp(d, "pc2", 64'(a_pc2), 64'(m_pc[d][2]));

    if (!rst) begin
      if (s < 3 && e_gnt) begin
        m_cur[d] = s;
        m_cnt[d]++;
      end
      if (take) m_cnt[d]--;
      m_err[d] = (s == 3) && e_gnt;
      for (int i = 0; i < 3; i++) begin
        if (clr) m_pc[d][i] = 0;
        else if (e_stall[i] && m_pc[d][i] < sat[d]) m_pc[d][i]++;
      end
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, gnt_a, rv_a, ro_a, rd_a, treq_a, stall_a, tadd_a, twen_a,
              tdata_a, tbe_a, int'(pc_a[0]), int'(pc_a[1]), int'(pc_a[2]));
    check_dut(1, gnt_b, rv_b, ro_b, rd_b, treq_b, stall_b, tadd_b, twen_b,
              tdata_b, tbe_b, int'(pc_b[0]), int'(pc_b[1]), int'(pc_b[2]));
  end

  // ---------------- driver tasks ----------------
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    req = 1'b0; add = '0; wen = 1'b1; wdata = '0; be = '0;
    tgt_gnt = 3'b111; tgt_rv = '0; tgt_ro = '0; clr = 1'b0;
    for (int i = 0; i < 3; i++) tgt_rd[i] = 32'hF000_0000 | 32'(i);
  endtask

  task automatic set_req(input logic r, input logic [31:0] a);
    req = r; add = a; wen = 1'b1;
    wdata = $urandom; be = 4'($urandom_range(0, 15));
  endtask

  task automatic set_rsp(input int t, input logic [31:0] d, input logic o);
    tgt_rv = '0; tgt_ro = '0;
    for (int i = 0; i < 3; i++) tgt_rd[i] = 32'hF000_0000 | 32'(i);
    tgt_rv[t] = 1'b1; tgt_rd[t] = d; tgt_ro[t] = o;
  endtask

  task automatic no_rsp();
    tgt_rv = '0; tgt_ro = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle();
    settle();
    adv();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    // Reset state
    settle();
    cmp(0, "rst_gnt", 64'(gnt_a), 64'd0);
    cmp(1, "rst_rv", 64'(rv_b), 64'd0);
    cmp(0, "rst_rdata", 64'(rd_a), 64'd0);
    cmp(1, "rst_pc0", 64'(pc_b[0]), 64'd0);
    adv();
    rst = 1'b0;

    // Four back-to-back reads to target 0, responses two cycles after grant
    for (int c = 0; c < 7; c++) begin
      set_req(c < 4, 32'h1000_0010);
      if (c >= 2 && c <= 5) set_rsp(0, 32'h0000_00A0 + 32'(c - 2), 1'b0);
      else no_rsp();
      settle();
      if (c < 4) cmp(0, "b2b_gnt", 64'(gnt_a), 64'd1);
      if (c == 0) cmp(0, "b2b_treq", 64'(treq_a), 64'b001);
      if (c == 2) cmp(1, "full_gnt", 64'(gnt_b), 64'd0);
      if (c >= 2 && c <= 5) cmp(0, "b2b_rdata", 64'(rd_a), 64'h0A0 + 64'(c - 2));
      adv();
    end

    // Target never responds: occupancy limit and stall counting
    pulse_reset();
    for (int c = 0; c < 7; c++) begin
      set_req(c < 6, 32'h1000_0010);
      settle();
      if (c == 2) cmp(1, "lim_gnt", 64'(gnt_b), 64'd0);
      if (c == 2) cmp(1, "lim_stall", 64'(stall_b), 64'b001);
      if (c >= 3) cmp(1, "lim_pc", 64'(pc_b[0]), 64'(c - 2));
      adv();
    end

    // Reset with transactions in flight, then a late response is dropped
    pulse_reset();
    set_rsp(0, 32'h1234_5678, 1'b0);
    settle();
    cmp(0, "late_rv", 64'(rv_a), 64'd0);
    cmp(1, "late_rv", 64'(rv_b), 64'd0);
    adv();
    idle();

    // Target switch: target-1 request waits for target 0 to drain
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) set_req(1'b1, 32'h1000_0010);
      if (c >= 1 && c <= 3) set_req(1'b1, 32'h2000_0040);
      if (c == 2) set_rsp(0, 32'h0000_0055, 1'b0);
      if (c == 4) set_rsp(1, 32'h0000_0066, 1'b0);
      settle();
      if (c == 1 || c == 2) cmp(0, "sw_hold", 64'(gnt_a), 64'd0);
      if (c == 1) cmp(0, "sw_stall", 64'(stall_a), 64'b010);
      if (c == 2) cmp(0, "sw_rdata0", 64'(rd_a), 64'h55);
      if (c == 3) cmp(0, "sw_treq", 64'(treq_a), 64'b010);
      if (c == 3) cmp(1, "sw_gnt", 64'(gnt_b), 64'd1);
      if (c == 4) cmp(1, "sw_rdata1", 64'(rd_b), 64'h66);
      adv();
    end

    // Unmapped access, then target 2 (rule 2) with an error-flagged response
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) set_req(1'b1, 32'hDEAD_0000);
      if (c == 2) set_req(1'b1, 32'h1A00_0000);
      if (c == 3) set_rsp(2, 32'h0000_0077, 1'b1);
      settle();
      if (c == 0) cmp(0, "err_gnt", 64'(gnt_a), 64'd1);
      if (c == 0) cmp(0, "err_treq", 64'(treq_a), 64'b000);
      if (c == 1) cmp(0, "err_rsp", {31'd0, rv_a, 31'd0, ro_a}, {31'd0, 1'b1, 31'd0, 1'b1});
      if (c == 1) cmp(1, "err_rdata", 64'(rd_b), 64'hBADA_CCE5);
      if (c == 2) cmp(0, "t2_treq", 64'(treq_a), 64'b100);
      if (c == 3) cmp(1, "t2_opc", 64'(ro_b), 64'd1);
      adv();
    end

    // Spurious responses: idle pipeline, and wrong target while busy
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) set_rsp(2, 32'h0000_0099, 1'b0);
      if (c == 1) set_req(1'b1, 32'h1000_0010);
      if (c == 2) set_rsp(2, 32'h0000_0098, 1'b0);
      if (c == 3) set_rsp(0, 32'h0000_0042, 1'b0);
      settle();
      if (c == 0) cmp(0, "spur_rv", 64'(rv_a), 64'd0);
      if (c == 1) cmp(0, "spur_gnt", 64'(gnt_a), 64'd1);
      if (c == 2) cmp(1, "wrong_tgt_rv", 64'(rv_b), 64'd0);
      if (c == 3) cmp(1, "right_tgt_rd", 64'(rd_b), 64'h42);
      adv();
    end

    // 20 stall cycles on target 0, then clear coinciding with a stall
    pulse_reset();
    for (int c = 0; c < 22; c++) begin
      idle();
      tgt_gnt = 3'b110;
      set_req(c < 21, 32'h1000_0010);
      clr = (c == 20);
      settle();
      if (c == 20) cmp(1, "sat_pc", 64'(pc_b[0]), 64'd15);
      if (c == 20) cmp(0, "wide_pc", 64'(pc_a[0]), 64'd20);
      if (c == 21) cmp(1, "clr_pc", 64'(pc_b[0]), 64'd0);
      if (c == 21) cmp(0, "clr_pc", 64'(pc_a[0]), 64'd0);
      adv();
    end

    idle();
    repeat (2) adv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
